// File: rtl/count_display.sv
// count_display: 12-bit binary to BCD converter (double dabble) with a 4-digit multiplexed 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
`default_nettype none

module count_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] count,
  input  logic        hold,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] shreg;
  logic [15:0] scratch;
  logic [3:0]  step;
  logic [15:0] adj;

  // Double-dabble correction: any BCD digit of 5 or more gets 3 added before the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      scratch   <= '0;
      step      <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!hold) begin
            shreg   <= count;
            scratch <= '0;
            step    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj[14:0], shreg, 1'b0};
          step             <= step + 4'd1;
          if (step == 4'd11) state <= DONE;
        end
        DONE: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [3:0] digit;

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;
  // lead_zero[i]: digit i and every higher digit are zero; digit 0 is never blanked.
  assign lead_zero = {bcd[15:12] == 4'd0, bcd[15:8] == 8'd0, bcd[15:4] == 12'd0, 1'b0};
`endif

  // Segments follow the registered bcd directly so a mid-dwell update shows at once.
  always_comb begin
    digit = 4'd0;
    unique case (idx)
      2'd0: digit = bcd[3:0];
      2'd1: digit = bcd[7:4];
      2'd2: digit = bcd[11:8];
      2'd3: digit = bcd[15:12];
      default: digit = 4'd0;
    endcase
    an  = ~(4'b0001 << idx);
    seg = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (lead_zero[idx]) seg = 7'b1111111;
`endif
  end

  assign dp = 1'b1;

endmodule

`default_nettype wire
